// File: rtl/core_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_fetch_unit_pkg
// Description : Shared constants, fetch FSM encodings and the parcel helper
//               used by the instruction-fetch stage and its realign buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package core_fetch_unit_pkg;

    // One RISC-V instruction parcel
    localparam int c_parcel_width = 16;

    // Realign buffer depth in parcels
    localparam int c_buf_depth = 3;

    // Fetch FSM encoding
    localparam int                          c_fetch_st_width = 2;
    localparam logic [c_fetch_st_width-1:0] c_fetch_req      = 2'd0;
    localparam logic [c_fetch_st_width-1:0] c_fetch_wait     = 2'd1;
    localparam logic [c_fetch_st_width-1:0] c_fetch_drop     = 2'd2;

    // Default first fetch address after reset
    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;

    // A parcel whose two low bits are not 2'b11 is a complete 16-bit instruction
    function automatic logic is_compressed(input logic [c_parcel_width-1:0] parcel);
        return (parcel[1:0] != 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_fetch_realign_buffer.sv
`default_nettype none
// ============================================================================
// Module      : core_fetch_realign_buffer
// Description : Three-parcel realignment buffer. Accepts 32-bit words (or
//               only their upper parcel), pops one or two parcels per
//               consumed instruction and composes the head instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module core_fetch_realign_buffer
    import core_fetch_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  logic                        i_push_upper_only,
    input  logic [2*c_parcel_width-1:0] i_push_word,
    input  logic                        i_pop,
    output logic [1:0]                  o_count,
    output logic                        o_valid,
    output logic [2*c_parcel_width-1:0] o_instr,
    output logic                        o_compressed
);

    logic [c_parcel_width-1:0] r_parcel     [c_buf_depth];
    logic [1:0]                r_count;

    logic [c_parcel_width-1:0] w_shift      [c_buf_depth];
    logic [c_parcel_width-1:0] w_parcel_nxt [c_buf_depth];
    logic [1:0]                w_count_nxt;
    logic                      w_head_compressed;
    logic                      w_valid;
    logic [1:0]                w_pop_n;
    logic [1:0]                w_push_n;
    logic [1:0]                w_base;
    logic [c_parcel_width-1:0] w_push_lo;

    assign w_head_compressed = is_compressed(r_parcel[0]);

    // A 32-bit instruction is only presented once both of its parcels are held
    assign w_valid = (r_count >= 2'd2) || ((r_count == 2'd1) && w_head_compressed);

    assign w_pop_n   = (i_pop && w_valid) ? (w_head_compressed ? 2'd1 : 2'd2) : 2'd0;
    assign w_push_n  = i_push ? (i_push_upper_only ? 2'd1 : 2'd2) : 2'd0;
    assign w_base    = r_count - w_pop_n;
    assign w_push_lo = i_push_upper_only ? i_push_word[2*c_parcel_width-1:c_parcel_width]
                                         : i_push_word[c_parcel_width-1:0];

    // Next-state: shift out popped parcels, then append pushed parcels behind the survivors
    always_comb begin
        for (int i = 0; i < c_buf_depth; i++) begin
            w_shift[i]      = '0;
            w_parcel_nxt[i] = '0;
        end
        w_count_nxt = r_count;

        case (w_pop_n)
            2'd1: begin
                w_shift[0] = r_parcel[1];
                w_shift[1] = r_parcel[2];
            end
            2'd2: begin
                w_shift[0] = r_parcel[2];
            end
            default: begin
                for (int i = 0; i < c_buf_depth; i++) begin
                    w_shift[i] = r_parcel[i];
                end
            end
        endcase

        for (int i = 0; i < c_buf_depth; i++) begin
            w_parcel_nxt[i] = w_shift[i];
            if ((w_push_n != 2'd0) && (3'(i) == {1'b0, w_base})) begin
                w_parcel_nxt[i] = w_push_lo;
            end
            if ((w_push_n == 2'd2) && (3'(i) == ({1'b0, w_base} + 3'd1))) begin
                w_parcel_nxt[i] = i_push_word[2*c_parcel_width-1:c_parcel_width];
            end
        end
        w_count_nxt = w_base + w_push_n;

        if (i_flush) begin
            for (int i = 0; i < c_buf_depth; i++) begin
                w_parcel_nxt[i] = '0;
            end
            w_count_nxt = 2'd0;
        end
    end

    // Parcel storage and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_buf_depth; i++) begin
                r_parcel[i] <= '0;
            end
            r_count <= 2'd0;
        end else begin
            for (int i = 0; i < c_buf_depth; i++) begin
                r_parcel[i] <= w_parcel_nxt[i];
            end
            r_count <= w_count_nxt;
        end
    end

    assign o_count      = r_count;
    assign o_valid      = w_valid;
    assign o_compressed = w_valid && w_head_compressed;
    assign o_instr      = !w_valid          ? '0 :
                          w_head_compressed ? {{c_parcel_width{1'b0}}, r_parcel[0]} :
                                              {r_parcel[1], r_parcel[0]};

endmodule
`default_nettype wire

// File: rtl/core_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : core_fetch_unit
// Description : Instruction-fetch stage. Owns the fetch address and the PC
//               of the instruction presented to decode, runs the single-
//               outstanding request FSM and applies branch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module core_fetch_unit
    import core_fetch_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = c_reset_pc_default
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  branch_i,
    input  logic [DATA_WIDTH-1:0] brj_pc_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  instr_compressed_o
);

    localparam logic [DATA_WIDTH-1:0] c_step_half = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] c_step_word = DATA_WIDTH'(4);

    logic [c_fetch_st_width-1:0] r_state;
    logic [DATA_WIDTH-1:0]       r_fetch_addr;
    logic [DATA_WIDTH-1:0]       r_instr_pc;
    logic                        r_skip_upper;
    logic                        r_run;

    logic                        w_req;
    logic                        w_push;
    logic                        w_consume;
    logic [1:0]                  w_count;
    logic                        w_valid;
    logic [DATA_WIDTH-1:0]       w_instr;
    logic                        w_compressed;
    logic [DATA_WIDTH-1:0]       w_target_word;
    logic [DATA_WIDTH-1:0]       w_target_pc;

    // r_run holds the request low for the first cycle out of reset
    assign w_req = r_run && (r_state == c_fetch_req) && (w_count <= 2'd1);

    // Data is only accepted for a live request; redirect kills same-cycle data
    assign w_push    = (r_state == c_fetch_wait) && imem_rvalid_i && !branch_i;
    assign w_consume = w_valid && !stall_i && !branch_i;

    assign w_target_word = brj_pc_i & ~DATA_WIDTH'(3);
    assign w_target_pc   = brj_pc_i & ~DATA_WIDTH'(1);

    core_fetch_realign_buffer u_realign (
        .clk               (clk_i),
        .rst               (rst_i),
        .i_flush           (branch_i),
        .i_push            (w_push),
        .i_push_upper_only (r_skip_upper),
        .i_push_word       (imem_rdata_i),
        .i_pop             (w_consume),
        .o_count           (w_count),
        .o_valid           (w_valid),
        .o_instr           (w_instr),
        .o_compressed      (w_compressed)
    );

    // Request FSM: one outstanding request; a redirect turns a live response into a dead one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_fetch_req;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (branch_i) begin
                case (r_state)
                    c_fetch_req:  r_state <= (w_req && imem_gnt_i) ? c_fetch_drop : c_fetch_req;
                    c_fetch_wait,
                    c_fetch_drop: r_state <= imem_rvalid_i ? c_fetch_req : c_fetch_drop;
                    default:      r_state <= c_fetch_req;
                endcase
            end else begin
                case (r_state)
                    c_fetch_req:  if (w_req && imem_gnt_i) r_state <= c_fetch_wait;
                    c_fetch_wait: if (imem_rvalid_i)       r_state <= c_fetch_req;
                    c_fetch_drop: if (imem_rvalid_i)       r_state <= c_fetch_req;
                    default:                               r_state <= c_fetch_req;
                endcase
            end
        end
    end

    // Fetch address: retarget on redirect, otherwise advance by a word on each grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_addr <= RESET_PC & ~DATA_WIDTH'(3);
        end else if (branch_i) begin
            r_fetch_addr <= w_target_word;
        end else if (w_req && imem_gnt_i) begin
            r_fetch_addr <= r_fetch_addr + c_step_word;
        end
    end

    // Halfword-target flag: the first word after a redirect to bit1=1 contributes only its upper parcel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_skip_upper <= RESET_PC[1];
        end else if (branch_i) begin
            r_skip_upper <= brj_pc_i[1];
        end else if (w_push) begin
            r_skip_upper <= 1'b0;
        end
    end

    // PC of the presented instruction advances by its size when decode takes it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_instr_pc <= RESET_PC;
        end else if (branch_i) begin
            r_instr_pc <= w_target_pc;
        end else if (w_consume) begin
            r_instr_pc <= r_instr_pc + (w_compressed ? c_step_half : c_step_word);
        end
    end

    assign imem_req_o         = w_req;
    assign imem_addr_o        = r_fetch_addr;
    assign instr_valid_o      = w_valid;
    assign instr_o            = w_instr;
    assign instr_pc_o         = r_instr_pc;
    assign instr_compressed_o = w_compressed;

endmodule
`default_nettype wire
